// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - N-port cache block fill controller over one shared pipelined memory
// Optional macro FILL_RR_ARB_EN: round-robin grant; default build uses fixed lowest-index priority.
module cache_fill_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        miss_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] miss_addr,
    input  logic                        mem_data_valid,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        busy,
    output logic [NUM_PORTS-1:0]        stall,
    output logic [NUM_PORTS-1:0]        write_data_array,
    output logic [NUM_PORTS-1:0]        write_tag_array,
    output logic [ADDR_W-1:0]           fill_addr
);
    localparam int CW = $clog2(BLOCK_WORDS) + 1;
    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0]     CNT_FULL   = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0]     CNT_LAST   = CW'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state, state_d;
    logic [OW-1:0]       owner, owner_d, grant_idx;
    logic [ADDR_W-1:0]   base, base_d;
    logic [CW-1:0]       issue_cnt, issue_d, recv_cnt, recv_d;
    logic [ADDR_W-1:0]   port_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] owner_oh;
    logic                wr_fire;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port_addr
        assign port_addr[i] = miss_addr[i*ADDR_W +: ADDR_W];
    end

`ifdef FILL_RR_ARB_EN
    logic [OW-1:0] rr_ptr;
    logic          rr_found;

    // First requester at or after rr_ptr, wrapping around the port list.
    always_comb begin
        grant_idx = '0;
        rr_found  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!rr_found && miss_req[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                rr_found  = 1'b1;
                grant_idx = OW'((int'(rr_ptr) + k) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == IDLE && |miss_req) begin
            rr_ptr <= OW'((int'(grant_idx) + 1) % NUM_PORTS);
        end
    end
`else
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (miss_req[k]) grant_idx = OW'(k);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            base      <= base_d;
            issue_cnt <= issue_d;
            recv_cnt  <= recv_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        base_d  = base;
        issue_d = issue_cnt;
        recv_d  = recv_cnt;
        case (state)
            IDLE: begin
                if (|miss_req) begin
                    state_d = FILL;
                    owner_d = grant_idx;
                    base_d  = port_addr[grant_idx] & ALIGN_MASK;
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
            FILL: begin
                if (issue_cnt < CNT_FULL) issue_d = issue_cnt + 1'b1;
                // Returns are counted independently of issues so any latency or gap pattern works.
                if (mem_data_valid) begin
                    recv_d = recv_cnt + 1'b1;
                    if (recv_cnt == CNT_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state == FILL);
    assign owner_oh = NUM_PORTS'(1) << owner;
    assign mem_en   = busy && (issue_cnt < CNT_FULL);
    assign mem_addr = mem_en ? base + (ADDR_W'(issue_cnt) << 1) : '0;
    assign wr_fire  = busy && mem_data_valid;

    assign write_data_array = wr_fire ? owner_oh : '0;
    assign write_tag_array  = (wr_fire && recv_cnt == CNT_LAST) ? owner_oh : '0;
    assign fill_addr        = wr_fire ? base + (ADDR_W'(recv_cnt) << 1) : '0;
    assign stall            = miss_req | (busy ? owner_oh : '0);
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl (2-port/8-word and 4-port/4-word)
module tb_cache_fill_ctrl;
    logic        clk;
    logic        rst0, rst1, v0, v1;
    logic [1:0]  req0;
    logic [31:0] addr0;
    logic [3:0]  req1;
    logic [63:0] addr1;
    logic        en0, busy0, en1, busy1;
    logic [15:0] ma0, fa0, ma1, fa1;
    logic [1:0]  st0, wd0, wt0;
    logic [3:0]  st1, wd1, wt1;

    cache_fill_ctrl #(.NUM_PORTS(2), .ADDR_W(16), .BLOCK_WORDS(8)) u0 (
        .clk(clk), .rst(rst0), .miss_req(req0), .miss_addr(addr0), .mem_data_valid(v0),
        .mem_en(en0), .mem_addr(ma0), .busy(busy0), .stall(st0),
        .write_data_array(wd0), .write_tag_array(wt0), .fill_addr(fa0));

    cache_fill_ctrl #(.NUM_PORTS(4), .ADDR_W(16), .BLOCK_WORDS(4)) u1 (
        .clk(clk), .rst(rst1), .miss_req(req1), .miss_addr(addr1), .mem_data_valid(v1),
        .mem_en(en1), .mem_addr(ma1), .busy(busy1), .stall(st1),
        .write_data_array(wd1), .write_tag_array(wt1), .fill_addr(fa1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one fill in flight = owner, aligned base, words issued, words returned.
    int m_busy [2], m_owner [2], m_base [2], m_iss [2], m_rcv [2], m_rr [2];
    int np [2], bw [2];

    // Environment: caches hold a miss until their tag is written; memory returns in order.
    logic [3:0]  pend [2];
    logic [15:0] paddr [2][4];
    int          mq0 [$], mq1 [$];
    int          lat [2], gapmax [2];
    bit          env_on [2];
    int          tag_log0 [$];
    int          tag0_cyc, gap0, first_fa1, en_cnt0, wr_cnt0, v_cnt0;
    bit          stall_bad;
    int          vcnt1, tcnt1, tag_at1;
    bit          drop1;
    int          maddr_log1 [$];
    int          tbl_idx = -1;

    typedef struct {
        logic rst; logic [1:0] req; logic [15:0] addr; logic v;
        logic busy; logic en; logic [15:0] ma; logic [1:0] wd; logic [1:0] wt; logic [15:0] fa; logic [1:0] st;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input int d, input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL u%0d %s: got 0x%0h want 0x%0h (cycle %0d)", d, nm, act, exp, cyc);
        end
    endtask

    function automatic int in_req(input int d);
        return (d == 0) ? int'(req0) : int'(req1);
    endfunction

    function automatic int in_addr(input int d, input int p);
        return (d == 0) ? int'(addr0[p*16 +: 16]) : int'(addr1[p*16 +: 16]);
    endfunction

    task automatic check_dut(input int d);
        int rq, v, a_busy, a_en, a_ma, a_wd, a_wt, a_fa, a_st, own_oh, e_en, wr;
        if (d == 0) begin
            rq = int'(req0); v = int'(v0); a_busy = int'(busy0); a_en = int'(en0); a_ma = int'(ma0);
            a_wd = int'(wd0); a_wt = int'(wt0); a_fa = int'(fa0); a_st = int'(st0);
        end else begin
            rq = int'(req1); v = int'(v1); a_busy = int'(busy1); a_en = int'(en1); a_ma = int'(ma1);
            a_wd = int'(wd1); a_wt = int'(wt1); a_fa = int'(fa1); a_st = int'(st1);
        end
        own_oh = 1 << m_owner[d];
        e_en   = (m_busy[d] != 0 && m_iss[d] < bw[d]) ? 1 : 0;
        wr     = (m_busy[d] != 0 && v != 0) ? 1 : 0;
        chk(d, "busy", a_busy, m_busy[d]);
        chk(d, "mem_en", a_en, e_en);
        chk(d, "mem_addr", a_ma, (e_en != 0) ? ((m_base[d] + 2 * m_iss[d]) & 'hFFFF) : 0);
        chk(d, "write_data_array", a_wd, (wr != 0) ? own_oh : 0);
        chk(d, "write_tag_array", a_wt, (wr != 0 && m_rcv[d] == bw[d] - 1) ? own_oh : 0);
        chk(d, "fill_addr", a_fa, (wr != 0) ? ((m_base[d] + 2 * m_rcv[d]) & 'hFFFF) : 0);
        chk(d, "stall", a_st, rq | ((m_busy[d] != 0) ? own_oh : 0));
    endtask

    task automatic check_row(input int r);
        chk(0, $sformatf("tbl%0d_busy", r), int'(busy0), int'(tbl[r].busy));
        chk(0, $sformatf("tbl%0d_mem_en", r), int'(en0), int'(tbl[r].en));
        chk(0, $sformatf("tbl%0d_mem_addr", r), int'(ma0), int'(tbl[r].ma));
        chk(0, $sformatf("tbl%0d_wr_data", r), int'(wd0), int'(tbl[r].wd));
        chk(0, $sformatf("tbl%0d_wr_tag", r), int'(wt0), int'(tbl[r].wt));
        chk(0, $sformatf("tbl%0d_fill_addr", r), int'(fa0), int'(tbl[r].fa));
        chk(0, $sformatf("tbl%0d_stall", r), int'(st0), int'(tbl[r].st));
    endtask

    task automatic model_step(input int d);
        int rq, own, r, v;
        r  = (d == 0) ? int'(rst0) : int'(rst1);
        v  = (d == 0) ? int'(v0) : int'(v1);
        rq = in_req(d);
        if (r != 0) begin
            m_busy[d] = 0; m_owner[d] = 0; m_iss[d] = 0; m_rcv[d] = 0; m_rr[d] = 0;
        end else if (m_busy[d] == 0) begin
            if (rq != 0) begin
                own = -1;
`ifdef FILL_RR_ARB_EN
                for (int k = 0; k < np[d]; k++)
                    if (own < 0 && rq[(m_rr[d] + k) % np[d]]) own = (m_rr[d] + k) % np[d];
`else
                for (int k = 0; k < np[d]; k++)
                    if (own < 0 && rq[k]) own = k;
`endif
                m_owner[d] = own;
                m_base[d]  = in_addr(d, own) & ~(2 * bw[d] - 1) & 'hFFFF;
                m_iss[d]   = 0;
                m_rcv[d]   = 0;
                m_busy[d]  = 1;
                m_rr[d]    = (own + 1) % np[d];
            end
        end else begin
            if (m_iss[d] < bw[d]) m_iss[d] = m_iss[d] + 1;
            if (v != 0) begin
                m_rcv[d] = m_rcv[d] + 1;
                if (m_rcv[d] == bw[d]) m_busy[d] = 0;
            end
        end
    endtask

    task automatic env_drive(input int d);
        logic vv;
        vv = 1'b0;
        if (d == 0) begin
            if (mq0.size() > 0 && mq0[0] <= cyc && $urandom_range(0, gapmax[0]) == 0) vv = 1'b1;
            req0 = pend[0][1:0]; addr0 = {paddr[0][1], paddr[0][0]}; v0 = vv;
        end else begin
            if (mq1.size() > 0 && mq1[0] <= cyc && $urandom_range(0, gapmax[1]) == 0) vv = 1'b1;
            req1 = pend[1]; addr1 = {paddr[1][3], paddr[1][2], paddr[1][1], paddr[1][0]}; v1 = vv;
        end
    endtask

    task automatic env_observe(input int d);
        if (d == 0) begin
            if (v0) begin void'(mq0.pop_front()); v_cnt0++; end
            if (wd0 != 0) wr_cnt0++;
            if (en0) begin
                mq0.push_back(cyc + lat[0]);
                en_cnt0++;
                if (tag0_cyc >= 0 && gap0 < 0 && cyc > tag0_cyc) gap0 = cyc - tag0_cyc;
            end
            if (wd0[1] && first_fa1 < 0) first_fa1 = int'(fa0);
            if (busy0 && pend[0][1] && !st0[1]) stall_bad = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (wt0[p]) begin
                    pend[0][p] = 1'b0;
                    tag_log0.push_back(p);
                    if (p == 0) tag0_cyc = cyc;
                end
            end
        end else begin
            if (v1) begin
                void'(mq1.pop_front());
                vcnt1++;
                if (drop1 && vcnt1 == 2) pend[1][3] = 1'b0;
            end
            if (en1) begin mq1.push_back(cyc + lat[1]); maddr_log1.push_back(int'(ma1)); end
            if (wt1 != 0) begin
                tcnt1++;
                tag_at1 = vcnt1;
                for (int p = 0; p < 4; p++) if (wt1[p]) pend[1][p] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit chk_en);
        if (env_on[0]) env_drive(0);
        if (env_on[1]) env_drive(1);
        #1;
        if (chk_en) begin
            check_dut(0);
            check_dut(1);
            if (tbl_idx >= 0) check_row(tbl_idx);
        end
        if (env_on[0]) env_observe(0);
        if (env_on[1]) env_observe(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        np[0] = 2; bw[0] = 8; np[1] = 4; bw[1] = 4;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_owner[d] = 0; m_base[d] = 0; m_iss[d] = 0; m_rcv[d] = 0; m_rr[d] = 0;
            pend[d] = '0; env_on[d] = 1'b0; lat[d] = 4; gapmax[d] = 0;
            for (int p = 0; p < 4; p++) paddr[d][p] = '0;
        end
        tag0_cyc = -1; gap0 = -1; first_fa1 = -1; en_cnt0 = 0; wr_cnt0 = 0; v_cnt0 = 0; stall_bad = 1'b0;
        vcnt1 = 0; tcnt1 = 0; tag_at1 = -1; drop1 = 1'b0;

        // Single miss, port 0, 0x1236, memory latency 4: miss in row 1, grant edge, fill rows 2..13.
        tbl[0]  = '{1'b1, 2'b10, 16'h1236, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b10};
        tbl[1]  = '{1'b0, 2'b01, 16'h1236, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b01};
        tbl[2]  = '{1'b0, 2'b01, 16'h1236, 1'b0, 1'b1, 1'b1, 16'h1230, 2'b00, 2'b00, 16'h0000, 2'b01};
        tbl[3]  = '{1'b0, 2'b01, 16'h1236, 1'b0, 1'b1, 1'b1, 16'h1232, 2'b00, 2'b00, 16'h0000, 2'b01};
        tbl[4]  = '{1'b0, 2'b01, 16'h1236, 1'b0, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b00, 16'h0000, 2'b01};
        tbl[5]  = '{1'b0, 2'b01, 16'h1236, 1'b0, 1'b1, 1'b1, 16'h1236, 2'b00, 2'b00, 16'h0000, 2'b01};
        tbl[6]  = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b1, 16'h1238, 2'b01, 2'b00, 16'h1230, 2'b01};
        tbl[7]  = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b1, 16'h123A, 2'b01, 2'b00, 16'h1232, 2'b01};
        tbl[8]  = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b1, 16'h123C, 2'b01, 2'b00, 16'h1234, 2'b01};
        tbl[9]  = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b1, 16'h123E, 2'b01, 2'b00, 16'h1236, 2'b01};
        tbl[10] = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 16'h1238, 2'b01};
        tbl[11] = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 16'h123A, 2'b01};
        tbl[12] = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 16'h123C, 2'b01};
        tbl[13] = '{1'b0, 2'b01, 16'h1236, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b01, 16'h123E, 2'b01};
        tbl[14] = '{1'b0, 2'b00, 16'h1236, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b00};

        rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
        req0 = '0; addr0 = '0; req1 = '0; addr1 = '0;
        cycle(1'b0);
        cycle(1'b0);
        rst1 = 1'b0;

        for (int r = 0; r < 15; r++) begin
            rst0 = tbl[r].rst; req0 = tbl[r].req; addr0 = {16'h0000, tbl[r].addr}; v0 = tbl[r].v;
            tbl_idx = r;
            cycle(1'b1);
        end
        tbl_idx = -1;

        // Simultaneous misses on both ports, three rounds.
        env_on[0] = 1'b1; lat[0] = 4; gapmax[0] = 0;
        for (int round = 0; round < 3; round++) begin
            pend[0] = 4'b0011; paddr[0][0] = 16'h0040; paddr[0][1] = 16'h2000;
            tag0_cyc = -1; gap0 = -1; first_fa1 = -1; stall_bad = 1'b0;
            for (int k = 0; k < 100 && pend[0] != 0; k++) cycle(1'b1);
            chk(0, "dual_done", int'(pend[0]), 0);
            chk(0, "dual_bubble", gap0, 2);
            chk(0, "dual_base1", first_fa1, 'h2000);
            chk(0, "dual_stall1", int'(stall_bad), 0);
        end
        chk(0, "grant_count", tag_log0.size(), 6);
        for (int k = 0; k < 6; k++)
            chk(0, $sformatf("grant_order%0d", k), (k < tag_log0.size()) ? tag_log0[k] : -1, k % 2);

        // Reset three cycles into a fill; in-flight returns must not write.
        pend[0] = 4'b0001; paddr[0][0] = 16'h0100; en_cnt0 = 0;
        for (int k = 0; k < 50 && en_cnt0 < 3; k++) cycle(1'b1);
        chk(0, "rst_prefill_issues", en_cnt0, 3);
        rst0 = 1'b1; pend[0] = '0;
        cycle(1'b1);
        rst0 = 1'b0;
        chk(0, "rst_busy", int'(busy0), 0);
        chk(0, "rst_mem_en", int'(en0), 0);
        chk(0, "rst_strobes", int'(wd0 | wt0), 0);
        wr_cnt0 = 0; v_cnt0 = 0;
        for (int k = 0; k < 10; k++) cycle(1'b1);
        chk(0, "rst_ghost_writes", wr_cnt0, 0);
        chk(0, "rst_ghost_valids_seen", int'(v_cnt0 > 0), 1);
        pend[0] = 4'b0010; paddr[0][1] = 16'h3456; first_fa1 = -1;
        for (int k = 0; k < 100 && pend[0] != 0; k++) cycle(1'b1);
        chk(0, "refill_done", int'(pend[0]), 0);
        chk(0, "refill_base", first_fa1, 'h3450);
        chk(0, "refill_owner", (tag_log0.size() > 0) ? tag_log0[tag_log0.size() - 1] : -1, 1);
        env_on[0] = 1'b0; req0 = '0; addr0 = '0; v0 = 1'b0;
        mq0.delete();

        // Four ports, four-word blocks, irregular returns, owner drops its miss mid-fill.
        env_on[1] = 1'b1; lat[1] = 2; gapmax[1] = 3; drop1 = 1'b1;
        pend[1] = 4'b1000; paddr[1][3] = 16'hFFF8;
        for (int k = 0; k < 200 && tcnt1 == 0; k++) cycle(1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1);
        chk(1, "gap_tag_count", tcnt1, 1);
        chk(1, "gap_tag_on_valid", tag_at1, 4);
        chk(1, "gap_issue_count", maddr_log1.size(), 4);
        for (int k = 0; k < 4; k++)
            chk(1, $sformatf("gap_mem_addr%0d", k), (k < maddr_log1.size()) ? maddr_log1[k] : -1, 'hFFF8 + 2 * k);
        env_on[1] = 1'b0; req1 = '0; addr1 = '0; v1 = 1'b0;

        // Random traffic on both instances against the model.
        for (int k = 0; k < 1500; k++) begin
            rst0 = ($urandom_range(0, 39) == 0); rst1 = ($urandom_range(0, 39) == 0);
            req0 = 2'($urandom_range(0, 3)); req1 = 4'($urandom_range(0, 15));
            addr0 = $urandom; addr1 = {$urandom, $urandom};
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            cycle(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
